// File: rtl/anchor_controller.sv
// anchor_controller: raster-order scan sequencer for a 3x3 filter window.
// It fetches pixel columns into the window buffer, launches one filter pass
// per anchor and signals the end of the frame.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | waiting for start; anchor outputs hold the last frame's values
// LOAD        | load_req high until load_ack; cols_left columns still missing
// MOVE        | window complete; anchor_moving pulses for this single cycle
// WAIT_FILTER | waiting for filter_done, then advance the anchor or finish
// DONE        | image_done pulses for one cycle, then back to IDLE
module anchor_controller #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int X_W   = 10,
    parameter int Y_W   = 9
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           start,
    input  logic           load_ack,
    input  logic           filter_done,
    output logic           load_req,
    output logic [X_W-1:0] load_col,
    output logic [Y_W-1:0] load_row,
    output logic           anchor_moving,
    output logic [X_W-1:0] anchor_x,
    output logic [Y_W-1:0] anchor_y,
    output logic           busy,
    output logic           image_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MOVE,
        WAIT_FILTER,
        DONE
    } state_t;

    // Last anchor positions; the scan never steps past these, so no wrap.
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 2);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 2);

    state_t     state;
    logic [1:0] cols_left;   // down-counter of columns still to fetch

    // Sequencer: state, column down-counter and all registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            cols_left     <= 2'd0;
            load_req      <= 1'b0;
            load_col      <= '0;
            load_row      <= '0;
            anchor_moving <= 1'b0;
            anchor_x      <= X_W'(1);
            anchor_y      <= Y_W'(1);
            busy          <= 1'b0;
            image_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        anchor_x  <= X_W'(1);
                        anchor_y  <= Y_W'(1);
                        load_col  <= '0;
                        load_row  <= '0;
                        cols_left <= 2'd3;
                        load_req  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_ack) begin
                        cols_left <= cols_left - 2'd1;
                        load_col  <= load_col + X_W'(1);
                        // Last column in: drop the request, window is valid.
                        if (cols_left == 2'd1) begin
                            state         <= MOVE;
                            load_req      <= 1'b0;
                            anchor_moving <= 1'b1;
                        end
                    end
                end
                MOVE: begin
                    anchor_moving <= 1'b0;
                    state         <= WAIT_FILTER;
                end
                WAIT_FILTER: begin
                    if (filter_done) begin
                        if (anchor_x < X_LAST) begin
                            // Slide right: only the new rightmost column is needed.
                            anchor_x  <= anchor_x + X_W'(1);
                            load_col  <= anchor_x + X_W'(2);
                            cols_left <= 2'd1;
                            load_req  <= 1'b1;
                            state     <= LOAD;
                        end else if (anchor_y < Y_LAST) begin
                            // Next row: refill the whole window from column 0.
                            anchor_x  <= X_W'(1);
                            anchor_y  <= anchor_y + Y_W'(1);
                            load_col  <= '0;
                            load_row  <= anchor_y;
                            cols_left <= 2'd3;
                            load_req  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            image_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    image_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    load_req      <= 1'b0;
                    anchor_moving <= 1'b0;
                    image_done    <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anchor_controller.sv
// Bench for anchor_controller: a 4x4 and a 3x3 instance driven with random
// handshake delays and spurious inputs, checked against the raster-scan rules.
module tb_anchor_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst, start, load_ack, filter_done, sel;
    logic start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    logic       a_req, a_mov, a_busy, a_done;
    logic [2:0] a_col, a_row, a_ax, a_ay;
    logic       b_req, b_mov, b_busy, b_done;
    logic [1:0] b_col, b_row, b_ax, b_ay;

    anchor_controller #(.IMG_W(4), .IMG_H(4), .X_W(3), .Y_W(3)) dut_a (
        .clk(clk), .n_rst(n_rst), .start(start_a), .load_ack(load_ack),
        .filter_done(filter_done), .load_req(a_req), .load_col(a_col),
        .load_row(a_row), .anchor_moving(a_mov), .anchor_x(a_ax),
        .anchor_y(a_ay), .busy(a_busy), .image_done(a_done)
    );

    anchor_controller #(.IMG_W(3), .IMG_H(3), .X_W(2), .Y_W(2)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_b), .load_ack(load_ack),
        .filter_done(filter_done), .load_req(b_req), .load_col(b_col),
        .load_row(b_row), .anchor_moving(b_mov), .anchor_x(b_ax),
        .anchor_y(b_ay), .busy(b_busy), .image_done(b_done)
    );

    // View of whichever instance is currently under test.
    logic       m_req, m_mov, m_busy, m_done;
    logic [2:0] m_col, m_row, m_ax, m_ay;
    assign m_req  = sel ? b_req  : a_req;
    assign m_mov  = sel ? b_mov  : a_mov;
    assign m_busy = sel ? b_busy : a_busy;
    assign m_done = sel ? b_done : a_done;
    assign m_col  = sel ? {1'b0, b_col} : a_col;
    assign m_row  = sel ? {1'b0, b_row} : a_row;
    assign m_ax   = sel ? {1'b0, b_ax}  : a_ax;
    assign m_ay   = sel ? {1'b0, b_ay}  : a_ay;

    int tests = 0;
    int fails = 0;
    int lq[$];
    int aq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Column loads that must have completed before the k-th filter pass.
    function automatic int need(input int k, input int w);
        return (k / (w - 2)) * w + 3 + (k % (w - 2));
    endfunction

    task automatic run_frame(input int ack_lo, input int ack_hi, input int fd_lo,
                             input int fd_hi, input bit spur, input bit abort);
        int w, h, total, loads, moves, dones, wait_cnt, fd_cnt, idx;
        bit fd_active, prev_req, prev_ack, prev_mov, prev_done;
        bit abort_pend, expect_done, finished;
        logic [2:0] prev_col, prev_row;
        w = sel ? 3 : 4;
        h = sel ? 3 : 4;
        total = (w - 2) * (h - 2);
        loads = 0; moves = 0; dones = 0; wait_cnt = 0; fd_cnt = 0;
        fd_active = 0; prev_req = 0; prev_ack = 0; prev_mov = 0; prev_done = 0;
        abort_pend = 0; expect_done = 0; finished = 0;
        prev_col = '0; prev_row = '0;
        lq.delete();
        aq.delete();

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("req_after_start", {31'd0, m_req}, 32'd1);

        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            @(negedge clk);
            load_ack = 1'b0;
            filter_done = 1'b0;
            start = 1'b0;
            if (abort_pend) begin
                #2 n_rst = 1'b0;
                #1;
                chk("abort_req", {31'd0, m_req}, 32'd0);
                chk("abort_busy", {31'd0, m_busy}, 32'd0);
                chk("abort_ax", {29'd0, m_ax}, 32'd1);
                chk("abort_ay", {29'd0, m_ay}, 32'd1);
                #1 n_rst = 1'b1;
                return;
            end
            if (expect_done) begin
                chk("done_after_fd", {31'd0, m_done}, 32'd1);
                expect_done = 0;
            end
            if (prev_req && !prev_ack && m_req) begin
                chk("col_stable", {29'd0, m_col}, {29'd0, prev_col});
                chk("row_stable", {29'd0, m_row}, {29'd0, prev_row});
            end
            if (prev_ack)
                chk("req_continuity", {31'd0, m_req}, (loads < need(moves, w)) ? 32'd1 : 32'd0);
            if (m_req && (!prev_req || prev_ack))
                wait_cnt = int'($urandom_range(ack_hi, ack_lo));
            prev_ack = 0;
            if (m_req) begin
                if (wait_cnt == 0) begin
                    load_ack = 1'b1;
                    prev_ack = 1;
                    lq.push_back(int'(m_col) * 8 + int'(m_row));
                    loads++;
                end else begin
                    wait_cnt--;
                    if (spur && $urandom_range(0, 1) == 1) filter_done = 1'b1;
                end
            end
            if (fd_active) begin
                if (fd_cnt == 0) begin
                    filter_done = 1'b1;
                    fd_active = 0;
                    if (moves == total) expect_done = 1;
                end else begin
                    fd_cnt--;
                    if (spur && $urandom_range(0, 1) == 1) load_ack = 1'b1;
                end
            end
            if (m_mov) begin
                chk("mov_one_cycle", {31'd0, prev_mov}, 32'd0);
                chk("loads_before_mov", loads, need(moves, w));
                aq.push_back(int'(m_ax) * 8 + int'(m_ay));
                moves++;
                fd_active = 1;
                fd_cnt = int'($urandom_range(fd_hi, fd_lo)) - 1;
                if (abort && m_ax == 3'd2 && m_ay == 3'd1) abort_pend = 1;
            end
            if (m_done) begin
                chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
                dones++;
                finished = 1;
            end else if (spur && m_busy && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
            end
            prev_req = m_req;
            prev_mov = m_mov;
            prev_done = m_done;
            prev_col = m_col;
            prev_row = m_row;
        end

        chk("frame_finished", {31'd0, finished}, 32'd1);
        chk("abort_reached", 32'd0, {31'd0, abort});
        @(negedge clk);
        chk("busy_after_done", {31'd0, m_busy}, 32'd0);
        chk("done_cleared", {31'd0, m_done}, 32'd0);
        chk("anchor_hold_x", {29'd0, m_ax}, w - 2);
        chk("anchor_hold_y", {29'd0, m_ay}, h - 2);
        chk("image_done_count", dones, 32'd1);
        chk("move_total", moves, total);
        chk("load_total", loads, w * (h - 2));
        idx = 0;
        for (int y = 1; y <= h - 2; y++)
            for (int c = 0; c < w; c++) begin
                if (idx < lq.size()) chk("load_seq", lq[idx], c * 8 + (y - 1));
                idx++;
            end
        idx = 0;
        for (int y = 1; y <= h - 2; y++)
            for (int x = 1; x <= w - 2; x++) begin
                if (idx < aq.size()) chk("anchor_seq", aq[idx], x * 8 + y);
                idx++;
            end
    endtask

    initial begin
        sel = 1'b0;
        n_rst = 1'b1;
        start = 1'b0;
        load_ack = 1'b0;
        filter_done = 1'b0;

        // Reset asserted mid-cycle, then a quiet idle period.
        #3 n_rst = 1'b0;
        #1;
        chk("rst_req", {31'd0, m_req}, 32'd0);
        chk("rst_busy", {31'd0, m_busy}, 32'd0);
        chk("rst_mov", {31'd0, m_mov}, 32'd0);
        chk("rst_done", {31'd0, m_done}, 32'd0);
        chk("rst_col", {29'd0, m_col}, 32'd0);
        chk("rst_ax", {29'd0, m_ax}, 32'd1);
        chk("rst_ay", {29'd0, m_ay}, 32'd1);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_no_req", {31'd0, m_req}, 32'd0);
        end

        // Reset while a column request is pending.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("req_before_rst", {31'd0, m_req}, 32'd1);
        n_rst = 1'b0;
        #1;
        chk("midrst_req", {31'd0, m_req}, 32'd0);
        chk("midrst_busy", {31'd0, m_busy}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        run_frame(0, 0, 3, 3, 1'b0, 1'b0);
        run_frame(5, 5, 1, 4, 1'b0, 1'b0);
        run_frame(0, 3, 1, 6, 1'b1, 1'b0);
        run_frame(0, 2, 1, 3, 1'b0, 1'b1);
        run_frame(0, 0, 2, 2, 1'b0, 1'b0);
        run_frame(0, 4, 1, 5, 1'b1, 1'b0);

        sel = 1'b1;
        run_frame(0, 0, 1, 1, 1'b0, 1'b0);
        run_frame(0, 3, 1, 4, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
